pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control.sv | 134 +++++++++++++
 tb/tb_pipe_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// pipe_control: ID-stage decode and control-bundle pipeline for a 5-stage core.
// Decodes the ID opcode into EX/MEM/WB control fields. It carries them through the
// ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and tracks
// unrecognised opcodes.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   valid_in          - ID stage holds a real instruction
//   opcode, rs, rt    - ID-stage instruction fields
//   flush             - squash the ID-stage instruction
//   clear_err         - clear sticky illegal flag and counter
//   ex_ctrl           - ID/EX {RegDst, ALUOp1, ALUOp0, ALUSrc}
//   m_ctrl            - EX/MEM {Branch, MemRead, MemWrite}
//   wb_ctrl           - MEM/WB {RegWrite, MemToReg}
//   stall             - freeze PC and IF/ID this cycle
//   illegal           - sticky unrecognised-opcode flag
//   illegal_cnt       - saturating count of unrecognised opcodes
module pipe_control #(
  parameter int REG_W     = 5,
  parameter int CNT_W     = 8,
  parameter int HAZARD_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [5:0]       opcode,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             flush,
  input  logic             clear_err,
  output logic [3:0]       ex_ctrl,
  output logic [2:0]       m_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic             stall,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  logic [3:0]       dec_ex;
  logic [2:0]       dec_m;
  logic [1:0]       dec_wb;
  logic             dec_legal;

  logic [3:0]       idex_ex;
  logic [2:0]       idex_m;
  logic [1:0]       idex_wb;
  logic [REG_W-1:0] idex_rt;
  logic [2:0]       exmem_m;
  logic [1:0]       exmem_wb;
  logic [1:0]       memwb_wb;

  logic             hazard;
  logic             issue;
  logic             count_ev;

  always_comb begin
    dec_ex    = 4'b0000;
    dec_m     = 3'b000;
    dec_wb    = 2'b00;
    dec_legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin dec_ex = 4'b1100; dec_m = 3'b000; dec_wb = 2'b10; end
      OP_LW:    begin dec_ex = 4'b0001; dec_m = 3'b010; dec_wb = 2'b11; end
      OP_SW:    begin dec_ex = 4'b0001; dec_m = 3'b001; dec_wb = 2'b00; end
      OP_BEQ:   begin dec_ex = 4'b0010; dec_m = 3'b100; dec_wb = 2'b00; end
      OP_ADDI:  begin dec_ex = 4'b0001; dec_m = 3'b000; dec_wb = 2'b10; end
      OP_NOP:   begin dec_ex = 4'b1000; dec_m = 3'b000; dec_wb = 2'b00; end
      default:  dec_legal = 1'b0;
    endcase
  end

  // ID/EX.m[1] is MemRead. Reset clears it, so stall is low while in reset.
  assign hazard = (HAZARD_EN != 0) && valid_in && idex_m[1] &&
                  ((idex_rt == rs) || (idex_rt == rt));
  assign stall  = hazard && !flush;
  assign issue  = valid_in && !flush && !stall;

  // Stalled illegal opcodes still count; only flushed ones are exempt.
  assign count_ev = valid_in && !dec_legal && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ex  <= '0;
      idex_m   <= '0;
      idex_wb  <= '0;
      idex_rt  <= '0;
      exmem_m  <= '0;
      exmem_wb <= '0;
      memwb_wb <= '0;
    end else begin
      // The bundle decodes to zero for illegal opcodes, so they issue as bubbles.
      if (issue) begin
        idex_ex <= dec_ex;
        idex_m  <= dec_m;
        idex_wb <= dec_wb;
        idex_rt <= rt;
      end else begin
        idex_ex <= '0;
        idex_m  <= '0;
        idex_wb <= '0;
        idex_rt <= '0;
      end
      exmem_m  <= idex_m;
      exmem_wb <= idex_wb;
      memwb_wb <= exmem_wb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else if (clear_err) begin
      // Clearing and counting in the same cycle leaves exactly one event recorded.
      illegal     <= count_ev;
      illegal_cnt <= count_ev ? CNT_W'(1) : '0;
    end else if (count_ev) begin
      illegal <= 1'b1;
      if (illegal_cnt != {CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign ex_ctrl = idex_ex;
  assign m_ctrl  = exmem_m;
  assign wb_ctrl = memwb_wb;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed scenarios plus random traffic against a
// latency/history reference model. A second instance runs with hazard detection off.
module tb_pipe_control;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_NOP = 6'b100000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [4:0] rt;
  } bnd_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       flush, clear_err;

  logic [3:0] ex_ctrl, ex0;
  logic [2:0] m_ctrl, m0;
  logic [1:0] wb_ctrl, wb0;
  logic       stall, stall0, illegal, illegal0;
  logic [7:0] illegal_cnt, cnt0;

  int n_chk = 0;
  int n_fail = 0;

  bnd_t h1[$];
  bnd_t h0[$];
  bit   exp_illegal;
  int   ill_n;

  always #5 clk = ~clk;

  pipe_control #(.REG_W(5), .CNT_W(8), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .rs(rs), .rt(rt),
    .flush(flush), .clear_err(clear_err), .ex_ctrl(ex_ctrl), .m_ctrl(m_ctrl),
    .wb_ctrl(wb_ctrl), .stall(stall), .illegal(illegal), .illegal_cnt(illegal_cnt));

  pipe_control #(.REG_W(5), .CNT_W(8), .HAZARD_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .rs(rs), .rt(rt),
    .flush(flush), .clear_err(clear_err), .ex_ctrl(ex0), .m_ctrl(m0),
    .wb_ctrl(wb0), .stall(stall0), .illegal(illegal0), .illegal_cnt(cnt0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {legal, ex, m, wb}
  function automatic logic [9:0] lookup(input logic [5:0] op);
    case (op)
      OP_R:    return {1'b1, 4'b1100, 3'b000, 2'b10};
      OP_LW:   return {1'b1, 4'b0001, 3'b010, 2'b11};
      OP_SW:   return {1'b1, 4'b0001, 3'b001, 2'b00};
      OP_BEQ:  return {1'b1, 4'b0010, 3'b100, 2'b00};
      OP_ADD:  return {1'b1, 4'b0001, 3'b000, 2'b10};
      OP_NOP:  return {1'b1, 4'b1000, 3'b000, 2'b00};
      default: return 10'b0;
    endcase
  endfunction

  // A load in the stage just ahead whose destination matches either source.
  function automatic bit haz(input bit en, input bnd_t ahead);
    return en && valid_in && ahead.m[1] && (ahead.rt == rs || ahead.rt == rt);
  endfunction

  function automatic bnd_t issued(input bit en, input bnd_t ahead);
    logic [9:0] lk;
    lk = lookup(opcode);
    if (valid_in && !flush && !haz(en, ahead))
      return {lk[8:0], rt};
    return '0;
  endfunction

  task automatic reset_model();
    h1 = '{bnd_t'(0), bnd_t'(0), bnd_t'(0)};
    h0 = '{bnd_t'(0), bnd_t'(0), bnd_t'(0)};
    exp_illegal = 1'b0;
    ill_n = 0;
  endtask

  task automatic model_edge();
    bnd_t b1, b0;
    bit   ev;
    logic [9:0] lk;
    b1 = issued(1'b1, h1[0]);
    b0 = issued(1'b0, h0[0]);
    h1.push_front(b1); void'(h1.pop_back());
    h0.push_front(b0); void'(h0.pop_back());
    lk = lookup(opcode);
    ev = valid_in && !lk[9] && !flush;
    if (clear_err) begin
      ill_n = ev ? 1 : 0;
      exp_illegal = ev;
    end else if (ev) begin
      ill_n++;
      exp_illegal = 1'b1;
    end
  endtask

  // Inputs are applied at the falling edge. Stall is checked before the rising
  // edge and registered outputs just after it.
  task automatic cyc();
    int ecnt;
    #1;
    chk("stall", stall, haz(1'b1, h1[0]) && !flush);
    chk("stall_off", stall0, 0);
    @(posedge clk);
    model_edge();
    #1;
    ecnt = (ill_n > 255) ? 255 : ill_n;
    chk("ex", ex_ctrl, h1[0].ex);
    chk("m", m_ctrl, h1[1].m);
    chk("wb", wb_ctrl, h1[2].wb);
    chk("illegal", illegal, exp_illegal);
    chk("cnt", illegal_cnt, ecnt);
    chk("ex_off", ex0, h0[0].ex);
    chk("m_off", m0, h0[1].m);
    chk("wb_off", wb0, h0[2].wb);
    chk("illegal_off", illegal0, exp_illegal);
    chk("cnt_off", cnt0, ecnt);
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input logic [5:0] op, input logic [4:0] s,
                        input logic [4:0] t, input bit f, input bit c);
    valid_in = v; opcode = op; rs = s; rt = t; flush = f; clear_err = c;
  endtask

  task automatic drive(input bit v, input logic [5:0] op, input logic [4:0] s,
                       input logic [4:0] t, input bit f, input bit c);
    set_in(v, op, s, t, f, c);
    cyc();
  endtask

  logic [5:0] ops[6];

  initial begin
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADD, OP_NOP};
    rst_n = 1'b0;
    set_in(0, OP_R, 0, 0, 0, 0);
    reset_model();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ex", ex_ctrl, 0);
    chk("rst_m", m_ctrl, 0);
    chk("rst_wb", wb_ctrl, 0);
    chk("rst_stall", stall, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    rst_n = 1'b1;

    // Back-to-back independent instructions
    drive(1, OP_R,   1, 2, 0, 0); chk("seq_ex_r", ex_ctrl, 4'b1100);
    drive(1, OP_LW,  3, 4, 0, 0); chk("seq_ex_lw", ex_ctrl, 4'b0001); chk("seq_m_r", m_ctrl, 3'b000);
    drive(1, OP_SW,  6, 7, 0, 0); chk("seq_ex_sw", ex_ctrl, 4'b0001); chk("seq_wb_r", wb_ctrl, 2'b10);
    chk("seq_m_lw", m_ctrl, 3'b010);
    drive(1, OP_BEQ, 8, 9, 0, 0); chk("seq_ex_beq", ex_ctrl, 4'b0010); chk("seq_wb_lw", wb_ctrl, 2'b11);
    chk("seq_m_sw", m_ctrl, 3'b001);
    drive(0, OP_R, 0, 0, 0, 0);   chk("seq_wb_sw", wb_ctrl, 2'b00); chk("seq_m_beq", m_ctrl, 3'b100);
    drive(0, OP_R, 0, 0, 0, 0);   chk("seq_wb_beq", wb_ctrl, 2'b00);
    drive(0, OP_R, 0, 0, 0, 0);

    // Load-use stall
    drive(1, OP_LW, 0, 5, 0, 0);
    set_in(1, OP_R, 5, 1, 0, 0);
    #1; chk("lu_stall", stall, 1); chk("lu_stall_off", stall0, 0);
    cyc(); chk("lu_bubble", ex_ctrl, 4'b0000);
    #1; chk("lu_release", stall, 0);
    cyc(); chk("lu_issue", ex_ctrl, 4'b1100);
    drive(0, OP_R, 0, 0, 0, 0);

    // Load-use with flush, and a flushed illegal opcode
    drive(1, OP_LW, 0, 5, 0, 0);
    set_in(1, OP_R, 5, 1, 1, 0);
    #1; chk("fl_stall", stall, 0);
    cyc(); chk("fl_bubble", ex_ctrl, 4'b0000); chk("fl_illegal", illegal, 0);
    drive(1, OP_BAD, 0, 0, 1, 0); chk("fl_bad_ill", illegal, 0); chk("fl_bad_cnt", illegal_cnt, 0);

    // Saturation and clear
    for (int i = 0; i < 300; i++) drive(1, OP_BAD, 0, 0, 0, 0);
    chk("sat_ill", illegal, 1); chk("sat_cnt", illegal_cnt, 255);
    drive(1, OP_BAD, 0, 0, 0, 1); chk("clr_bad_cnt", illegal_cnt, 1); chk("clr_bad_ill", illegal, 1);
    drive(0, OP_R, 0, 0, 0, 1);   chk("clr_cnt", illegal_cnt, 0); chk("clr_ill", illegal, 0);

    // Reset between edges with a load in EX/MEM
    drive(1, OP_LW, 0, 5, 0, 0);
    drive(0, OP_R, 0, 0, 0, 0);
    chk("mr_m_pre", m_ctrl, 3'b010);
    set_in(1, OP_R, 5, 5, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_m", m_ctrl, 0); chk("mr_ex", ex_ctrl, 0); chk("mr_stall", stall, 0);
    reset_model();
    #1 rst_n = 1'b1;
    set_in(0, OP_R, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mr_wb_not11", wb_ctrl == 2'b11, 0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 6'($urandom);
      drive($urandom_range(0, 9) < 8, op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
